// File: rtl/md_pad_ports.sv
// rtl/md_pad_ports.sv - controller-port emulator producing 3/6-button pad pin values
//
// Purpose:
//   Emulates PORTS independent controller pads on the board I/O ports. Each
//   port follows the console-driven TH line, runs a TH phase sequencer with an
//   idle timeout, and presents the active-low pad pin values for the current
//   phase. Bit6 (TH) is never driven by the pad.
//
// Ports:
//   MCLK       in   system clock, all state on the rising edge
//   SRES       in   asynchronous active-low reset
//   port_o     in   console output value, 7 bits per port, bit6 = TH
//   port_d     in   console tristate per bit, 1 = not driven (pulled up)
//   btn        in   12 buttons per port, active-high pressed
//                   (Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode)
//   pad6       in   per port: 1 = 6-button pad, 0 = 3-button pad
//   connected  in   per port: 0 = nothing plugged in
//   pad_i      out  registered pad-side pin values, 7 bits per port
//   phase      out  per-port sequencer phase, 3 bits per port

module md_pad_ports #(
   parameter int PORTS   = 2,
   parameter int TIMEOUT = 80000,
   parameter int CNT_W   = 17
) (
   input  logic                 MCLK,
   input  logic                 SRES,
   input  logic [7*PORTS-1:0]   port_o,
   input  logic [7*PORTS-1:0]   port_d,
   input  logic [12*PORTS-1:0]  btn,
   input  logic [PORTS-1:0]     pad6,
   input  logic [PORTS-1:0]     connected,
   output logic [7*PORTS-1:0]   pad_i,
   output logic [3*PORTS-1:0]   phase
);

   // Pin data D5..D0 for a phase; pins are active-low so a pressed button reads 0.
   function automatic logic [5:0] pad_data(input logic [2:0] ph, input logic [11:0] b);
      logic [11:0] p;
      logic [5:0]  d;
      p = ~b;
      case (ph)
         3'd1, 3'd3: d = {p[7], p[4], 2'b00, p[1], p[0]};
         3'd5:       d = {p[7], p[4], 4'b0000};
         3'd6:       d = {p[6], p[5], p[11], p[8], p[9], p[10]};
         3'd7:       d = {p[7], p[4], 4'b1111};
         default:    d = {p[6], p[5], p[3], p[2], p[1], p[0]};
      endcase
      return d;
   endfunction

   // Only the TH bit of the console drive matters to the pad.
   logic w_unused_pins;
   assign w_unused_pins = ^{port_o, port_d};

   genvar k;
   generate
      for (k = 0; k < PORTS; k++) begin : g_port
         logic             w_th;
         logic             w_edge;
         logic             w_tmo;
         logic [11:0]      w_btn;
         logic [2:0]       w_phase_nxt;
         logic [CNT_W-1:0] w_cnt_nxt;
         logic             r_th_s;
         logic             r_th_prev;
         logic [2:0]       r_phase;
         logic [CNT_W-1:0] r_cnt;
         logic [6:0]       r_pad;

         // An undriven TH pin floats high through the pull-up.
         assign w_th   = port_d[7*k+6] ? 1'b1 : port_o[7*k+6];
         assign w_btn  = btn[12*k +: 12];
         assign w_edge = r_th_s ^ r_th_prev;
         assign w_tmo  = (r_cnt == CNT_W'(TIMEOUT - 1));

         always_comb begin
            w_phase_nxt = r_phase;
            w_cnt_nxt   = r_cnt;
            if (w_edge) begin
               // An edge always wins over a timeout landing on the same cycle.
               w_cnt_nxt = '0;
               if (pad6[k]) begin
                  w_phase_nxt = r_phase + 3'd1;
               end else begin
                  w_phase_nxt = {2'b00, ~r_phase[0]};
               end
            end else begin
               if (r_cnt != CNT_W'(TIMEOUT)) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
               if (w_tmo) begin
                  // Idle too long: fall back to the first phase matching the TH level.
                  w_phase_nxt = {2'b00, ~r_th_s};
               end else if (!pad6[k]) begin
                  // 3-button pads only ever use phases 0/1; collapse if mode dropped.
                  w_phase_nxt = {2'b00, r_phase[0]};
               end
            end
         end

         always_ff @(posedge MCLK or negedge SRES) begin
            if (!SRES) begin
               r_th_s    <= 1'b1;
               r_th_prev <= 1'b1;
               r_phase   <= 3'd0;
               r_cnt     <= '0;
               r_pad     <= 7'h7f;
            end else begin
               r_th_s    <= w_th;
               r_th_prev <= r_th_s;
               r_phase   <= w_phase_nxt;
               r_cnt     <= w_cnt_nxt;
               // Output follows the next phase so pins move together with the phase.
               if (connected[k]) begin
                  r_pad <= {1'b1, pad_data(w_phase_nxt, w_btn)};
               end else begin
                  r_pad <= 7'h7f;
               end
            end
         end

         assign pad_i[7*k +: 7] = r_pad;
         assign phase[3*k +: 3] = r_phase;
      end
   endgenerate

endmodule

// File: tb/tb_md_pad_ports.sv
// tb/tb_md_pad_ports.sv - self-checking bench for md_pad_ports

module tb_md_pad_ports;
   localparam int PORTS   = 2;
   localparam int TIMEOUT = 100;

   logic                MCLK = 1'b0;
   logic                SRES = 1'b0;
   logic [7*PORTS-1:0]  port_o = '0;
   logic [7*PORTS-1:0]  port_d = '1;
   logic [12*PORTS-1:0] btn = '0;
   logic [PORTS-1:0]    pad6 = '0;
   logic [PORTS-1:0]    connected = '1;
   logic [7*PORTS-1:0]  pad_i;
   logic [3*PORTS-1:0]  phase;

   int n_cmp = 0;
   int n_bad = 0;

   md_pad_ports #(.PORTS(PORTS), .TIMEOUT(TIMEOUT), .CNT_W(17)) dut (
      .MCLK(MCLK), .SRES(SRES), .port_o(port_o), .port_d(port_d), .btn(btn),
      .pad6(pad6), .connected(connected), .pad_i(pad_i), .phase(phase)
   );

   always #5 MCLK = ~MCLK;

   // Expected pin value: each output pin D5..D0 is named by a source,
   // a button index 0..11, 12 = constant 0, 13 = constant 1.
   function automatic logic [6:0] exp_pad(input int ph, input logic [11:0] b, input bit conn);
      int          src[6];
      logic [13:0] ext;
      logic [6:0]  r;
      ext = {1'b1, 1'b0, ~b};
      case (ph)
         1, 3:    src = '{7, 4, 12, 12, 1, 0};
         5:       src = '{7, 4, 12, 12, 12, 12};
         6:       src = '{6, 5, 11, 8, 9, 10};
         7:       src = '{7, 4, 13, 13, 13, 13};
         default: src = '{6, 5, 3, 2, 1, 0};
      endcase
      r[6] = 1'b1;
      for (int i = 0; i < 6; i++) r[5-i] = ext[src[i]];
      return conn ? r : 7'h7f;
   endfunction

   // Reference model: TH sample history, phase as a number, cycles since last edge.
   bit         m_th1[PORTS];
   bit         m_th2[PORTS];
   int         m_ph[PORTS];
   int         m_idle[PORTS];
   logic [6:0] m_pad[PORTS];

   always @(posedge MCLK or negedge SRES) begin
      for (int p = 0; p < PORTS; p++) begin
         if (!SRES) begin
            m_th1[p] = 1; m_th2[p] = 1; m_ph[p] = 0; m_idle[p] = 0; m_pad[p] = 7'h7f;
         end else begin
            if (m_th1[p] != m_th2[p]) begin
               m_ph[p]   = pad6[p] ? (m_ph[p] + 1) % 8 : ((m_ph[p] % 2 == 0) ? 1 : 0);
               m_idle[p] = 0;
            end else if (m_idle[p] == TIMEOUT - 1) begin
               m_ph[p]   = m_th1[p] ? 0 : 1;
               m_idle[p] = TIMEOUT;
            end else begin
               if (!pad6[p]) m_ph[p] = m_ph[p] % 2;
               if (m_idle[p] < TIMEOUT) m_idle[p]++;
            end
            m_th2[p] = m_th1[p];
            m_th1[p] = port_d[7*p+6] ? 1'b1 : port_o[7*p+6];
            m_pad[p] = exp_pad(m_ph[p], btn[12*p +: 12], connected[p]);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string nm);
      for (int p = 0; p < PORTS; p++) begin
         chk($sformatf("%s model pad p%0d", nm, p), 32'(pad_i[7*p +: 7]), 32'(m_pad[p]));
         chk($sformatf("%s model phase p%0d", nm, p), 32'(phase[3*p +: 3]), 32'(m_ph[p]));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge MCLK);
   endtask

   task automatic set_th(input int p, input bit v);
      port_o[7*p+6] = v;
      port_d[7*p+6] = 1'b0;
   endtask

   typedef struct {
      bit          th;
      logic [11:0] b;
      bit          p6;
      bit          conn;
      logic [6:0]  epad;
      int          eph;
   } vec_t;

   vec_t vt[9];
   logic [6:0] six_pad[8];

   initial begin
      vt[0] = '{1'b0, 12'h090, 1'b0, 1'b1, 7'h43, 1};
      vt[1] = '{1'b1, 12'h090, 1'b0, 1'b1, 7'h7f, 0};
      vt[2] = '{1'b1, 12'h009, 1'b0, 1'b1, 7'h76, 0};
      vt[3] = '{1'b1, 12'h009, 1'b0, 1'b0, 7'h7f, 0};
      vt[4] = '{1'b0, 12'h022, 1'b0, 1'b1, 7'h71, 1};
      vt[5] = '{1'b0, 12'hfff, 1'b1, 1'b1, 7'h40, 1};
      vt[6] = '{1'b1, 12'h000, 1'b1, 1'b1, 7'h7f, 2};
      vt[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 7'h73, 3};
      vt[8] = '{1'b0, 12'h000, 1'b0, 1'b1, 7'h73, 1};
      // X+Mode pressed, indexed by phase
      six_pad = '{7'h7f, 7'h73, 7'h7f, 7'h73, 7'h7f, 7'h70, 7'h73, 7'h7f};

      // Reset then idle
      set_th(0, 1); set_th(1, 1);
      btn[11:0] = 12'h041;
      tick(3);
      chk("reset pad_i", 32'(pad_i), 32'h3fff);
      chk("reset phase", 32'(phase), 32'h0);
      SRES = 1'b1;
      tick(2);
      chk("release up+c pad0", 32'(pad_i[6:0]), 32'h5e);
      chk_model("release");

      // Table vectors on port 0
      for (int i = 0; i < 9; i++) begin
         set_th(0, vt[i].th);
         btn[11:0]    = vt[i].b;
         pad6[0]      = vt[i].p6;
         connected[0] = vt[i].conn;
         tick(2);
         chk($sformatf("vec%0d pad0", i), 32'(pad_i[6:0]), 32'(vt[i].epad));
         chk($sformatf("vec%0d phase0", i), 32'(phase[2:0]), 32'(vt[i].eph));
         chk_model($sformatf("vec%0d", i));
      end

      // Exact latency: button 1 edge, TH 2 edges
      btn[11:0] = 12'h090;
      tick(1);
      chk("btn latency pad0", 32'(pad_i[6:0]), 32'h43);
      set_th(0, 1);
      tick(1);
      chk("th lat1 phase0", 32'(phase[2:0]), 32'd1);
      chk("th lat1 pad0", 32'(pad_i[6:0]), 32'h43);
      tick(1);
      chk("th lat2 phase0", 32'(phase[2:0]), 32'd0);
      chk("th lat2 pad0", 32'(pad_i[6:0]), 32'h7f);

      // 6-button sequence, port1 unplugged
      pad6[0] = 1'b1;
      btn[11:0] = 12'h900;
      btn[23:12] = 12'h001;
      connected[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_th(0, (i % 2 == 0) ? 1'b0 : 1'b1);
         tick(20);
         chk($sformatf("six phase %0d", i), 32'(phase[2:0]), 32'((i + 1) % 8));
         chk($sformatf("six pad %0d", i), 32'(pad_i[6:0]), 32'(six_pad[(i + 1) % 8]));
         chk($sformatf("six unplugged p1 %0d", i), 32'(pad_i[13:7]), 32'h7f);
         chk_model("six");
      end
      connected[1] = 1'b1;
      tick(1);
      chk("reconnect p1", 32'(pad_i[13:7]), 32'h7e);

      // Timeout
      set_th(0, 0); tick(5);
      set_th(0, 1); tick(5);
      set_th(0, 0); tick(2);
      chk("tmo pre phase", 32'(phase[2:0]), 32'd3);
      tick(99);
      chk("tmo hold phase", 32'(phase[2:0]), 32'd3);
      tick(1);
      chk("tmo fired phase", 32'(phase[2:0]), 32'd1);
      chk_model("tmo");
      set_th(0, 1); tick(5);
      chk("tmo next phase", 32'(phase[2:0]), 32'd2);
      set_th(0, 0); tick(2);
      chk("tmo next2 phase", 32'(phase[2:0]), 32'd3);
      chk("tmo next2 pad", 32'(pad_i[6:0]), 32'h73);
      // Edge on the timeout cycle
      tick(98);
      set_th(0, 1);
      tick(1);
      chk("tmo coincide pre", 32'(phase[2:0]), 32'd3);
      tick(1);
      chk("tmo coincide phase", 32'(phase[2:0]), 32'd4);
      chk_model("coincide");

      // Reset mid-operation at phase 6
      set_th(0, 0); tick(5);
      set_th(0, 1); tick(5);
      chk("mid phase6", 32'(phase[2:0]), 32'd6);
      #2 SRES = 1'b0;
      #1;
      chk("async reset pad_i", 32'(pad_i), 32'h3fff);
      chk("async reset phase", 32'(phase), 32'h0);
      tick(2);
      SRES = 1'b1;
      tick(3);
      set_th(0, 0); tick(2);
      chk("post reset phase", 32'(phase[2:0]), 32'd1);
      chk_model("post reset");

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < PORTS; p++) begin
            int div;
            div = (c < 1500) ? 4 : 150;
            if ($urandom_range(div - 1) == 0) port_o[7*p+6] = ~port_o[7*p+6];
            if ($urandom_range(15) == 0) port_d[7*p+6] = $urandom_range(3) == 0;
            if ($urandom_range(7) == 0) btn[12*p +: 12] = 12'($urandom);
            if ($urandom_range(63) == 0) pad6[p] = ~pad6[p];
            if ($urandom_range(31) == 0) connected[p] = ~connected[p];
         end
         port_o[5:0]  = 6'($urandom);
         port_d[12:7] = 6'($urandom);
         tick(1);
         chk_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
